// File: rtl/exe_bcast_arbiter_if.sv
// Lane-side result handshake plus broadcast/ROB completion bus for exe_bcast_arbiter.
// master drives results in and flushes; slave is the arbiter.
interface exe_bcast_arbiter_if #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int MAP_W     = 6,
    parameter int TAG_W     = 8
);
    logic [NUM_LANES-1:0]        in_valid;
    logic [NUM_LANES-1:0]        in_ready;
    logic [NUM_LANES-1:0]        in_regwr;
    logic [NUM_LANES*MAP_W-1:0]  in_map;
    logic [NUM_LANES*5-1:0]      in_reg;
    logic [NUM_LANES*DATA_W-1:0] in_val;
    logic [NUM_LANES*TAG_W-1:0]  in_instr_num;
    logic                        flush_valid;
    logic [TAG_W-1:0]            flush_instr_num;
    logic                        broadcast_flag;
    logic [MAP_W-1:0]            broadcast_map;
    logic [4:0]                  broadcast_reg;
    logic [DATA_W-1:0]           broadcast_val;
    logic                        complete_flag_rob;
    logic [TAG_W-1:0]            exe_instr_num;
    logic [NUM_LANES-1:0]        lane_grant;

    modport master (
        output in_valid, in_regwr, in_map, in_reg, in_val, in_instr_num,
        output flush_valid, flush_instr_num,
        input  in_ready,
        input  broadcast_flag, broadcast_map, broadcast_reg, broadcast_val,
        input  complete_flag_rob, exe_instr_num, lane_grant
    );

    modport slave (
        input  in_valid, in_regwr, in_map, in_reg, in_val, in_instr_num,
        input  flush_valid, flush_instr_num,
        output in_ready,
        output broadcast_flag, broadcast_map, broadcast_reg, broadcast_val,
        output complete_flag_rob, exe_instr_num, lane_grant
    );
endinterface

// File: rtl/exe_bcast_arbiter.sv
// Per-lane result FIFOs arbitrated round-robin onto one registered broadcast/completion bus,
// with squashing of entries younger than a mispredict flush.
module exe_bcast_arbiter #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int MAP_W     = 6,
    parameter int TAG_W     = 8
) (
    input logic               CLK,
    input logic               RESET,
    exe_bcast_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [RR_W-1:0]  LAST_LANE = RR_W'(NUM_LANES - 1);

    logic              regwr_mem [NUM_LANES][DEPTH];
    logic [MAP_W-1:0]  map_mem   [NUM_LANES][DEPTH];
    logic [4:0]        reg_mem   [NUM_LANES][DEPTH];
    logic [DATA_W-1:0] val_mem   [NUM_LANES][DEPTH];
    logic [TAG_W-1:0]  tag_mem   [NUM_LANES][DEPTH];
    logic              live_q    [NUM_LANES][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [NUM_LANES];
    logic [PTR_W-1:0]  rd_ptr_q  [NUM_LANES];
    logic [CNT_W-1:0]  count_q   [NUM_LANES];
    logic [RR_W-1:0]   rr_q;

    logic [NUM_LANES-1:0] ready, push, pop, cand, grant;
    logic [RR_W-1:0]      grant_idx;
    logic                 any_grant;

    // Younger means a modular distance in [1, 2^(TAG_W-1)-1] ahead of the flush tag.
    function automatic logic is_younger(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] f);
        logic [TAG_W-1:0] d;
        d = t - f;
        return (d != '0) && !d[TAG_W-1];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            ready[i] = (count_q[i] != FULL_CNT);
            push[i]  = bus.in_valid[i] && ready[i] && (bus.in_instr_num[i*TAG_W +: TAG_W] != '0);
            cand[i]  = (count_q[i] != '0) && live_q[i][rd_ptr_q[i]] &&
                       !(bus.flush_valid && is_younger(tag_mem[i][rd_ptr_q[i]], bus.flush_instr_num));
        end
    end

    assign bus.in_ready = ready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!any_grant && cand[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = RR_W'(idx);
                grant[idx] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            pop[i] = (count_q[i] != '0) && (grant[i] || !live_q[i][rd_ptr_q[i]]);
        end
    end

    // NOTE: payload storage carries no reset; the live bits and pointers alone decide validity.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) begin
                regwr_mem[i][wr_ptr_q[i]] <= bus.in_regwr[i];
                map_mem[i][wr_ptr_q[i]]   <= bus.in_map[i*MAP_W +: MAP_W];
                reg_mem[i][wr_ptr_q[i]]   <= bus.in_reg[i*5 +: 5];
                val_mem[i][wr_ptr_q[i]]   <= bus.in_val[i*DATA_W +: DATA_W];
                tag_mem[i][wr_ptr_q[i]]   <= bus.in_instr_num[i*TAG_W +: TAG_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the later push write to a slot
    // deliberately overrides the flush clear of that same slot.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) live_q[i][j] <= 1'b0;
            end
            rr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (bus.flush_valid && is_younger(tag_mem[i][j], bus.flush_instr_num))
                        live_q[i][j] <= 1'b0;
                end
                if (push[i]) begin
                    live_q[i][wr_ptr_q[i]] <= !(bus.flush_valid &&
                        is_younger(bus.in_instr_num[i*TAG_W +: TAG_W], bus.flush_instr_num));
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (any_grant) rr_q <= (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.broadcast_flag    <= 1'b0;
            bus.complete_flag_rob <= 1'b0;
            bus.broadcast_map     <= '0;
            bus.broadcast_reg     <= '0;
            bus.broadcast_val     <= '0;
            bus.exe_instr_num     <= '0;
            bus.lane_grant        <= '0;
        end else begin
            bus.broadcast_flag    <= 1'b0;
            bus.complete_flag_rob <= 1'b0;
            bus.lane_grant        <= grant;
            if (any_grant) begin
                bus.broadcast_flag    <= regwr_mem[grant_idx][rd_ptr_q[grant_idx]];
                bus.complete_flag_rob <= 1'b1;
                bus.broadcast_map     <= map_mem[grant_idx][rd_ptr_q[grant_idx]];
                bus.broadcast_reg     <= reg_mem[grant_idx][rd_ptr_q[grant_idx]];
                bus.broadcast_val     <= val_mem[grant_idx][rd_ptr_q[grant_idx]];
                bus.exe_instr_num     <= tag_mem[grant_idx][rd_ptr_q[grant_idx]];
            end
        end
    end
endmodule
